// File: rtl/wor_line_rx.sv
// wor_line_rx: receiver for a wired-OR single-wire bus (0 recessive, 1 dominant).
// Frame: start bit 1, DATA_BITS data bits MSB first, optional even-parity bit,
// stop bit 0. Decisions are taken only on bit_tick using the synchronized line.
// Optional feature: define WOR_LINE_RX_PARITY_EN to add the parity bit, the PAR
// state and the parity_err output.
module wor_line_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_in,
    input  logic                 bit_tick,
    input  logic                 tx_active,
    input  logic                 tx_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 arb_lost,
    output logic                 busy
`ifdef WOR_LINE_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

`ifdef WOR_LINE_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ls;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_BITS-1:0]   shreg;

    // per-tick actions decoded from the current state
    logic start;
    logic shift;
    logic arb_hit;
    logic accept;
    logic stop_bad;
`ifdef WOR_LINE_RX_PARITY_EN
    logic par_ok;
    logic par_load;
    logic par_bad;
`endif

    // synchronizer chain on the bus line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end

    assign ls   = sync_q[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state and per-tick action decode; nothing moves without bit_tick
    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift      = 1'b0;
        arb_hit    = 1'b0;
        accept     = 1'b0;
        stop_bad   = 1'b0;
`ifdef WOR_LINE_RX_PARITY_EN
        par_load   = 1'b0;
        par_bad    = 1'b0;
`endif
        if (bit_tick) begin
            case (state)
                IDLE: begin
                    if (ls) begin
                        state_next = DATA;
                        start      = 1'b1;
                    end
                end
                DATA: begin
                    shift   = 1'b1;
                    arb_hit = tx_active & ~tx_bit & ls;
                    if (cnt == CNT_LAST) begin
`ifdef WOR_LINE_RX_PARITY_EN
                        state_next = PAR;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef WOR_LINE_RX_PARITY_EN
                PAR: begin
                    par_load   = 1'b1;
                    state_next = STOP;
                end
`endif
                STOP: begin
                    // a dominant stop bit is an error, never a new start
                    state_next = IDLE;
                    if (ls) stop_bad = 1'b1;
`ifdef WOR_LINE_RX_PARITY_EN
                    else if (!par_ok) par_bad = 1'b1;
`endif
                    else accept = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // datapath, sticky arbitration flag and registered result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            arb_lost   <= 1'b0;
`ifdef WOR_LINE_RX_PARITY_EN
            par_ok     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= accept;
            frame_err <= stop_bad;
`ifdef WOR_LINE_RX_PARITY_EN
            parity_err <= par_bad;
            if (par_load) par_ok <= (ls == ^shreg);
`endif
            if (start) begin
                cnt      <= '0;
                arb_lost <= 1'b0;
            end
            if (shift) begin
                shreg <= DATA_BITS'({shreg, ls});
                cnt   <= cnt + CNT_W'(1);
            end
            if (arb_hit) arb_lost <= 1'b1;
            if (accept)  rx_data  <= shreg;
        end
    end

endmodule

// File: doc/wor_line_rx.md
WOR_LINE_RX -- requirements
Module: wor_line_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on line_in, legal range 2..4.
REQ-003 clk, input, 1: single clock; all state updates on rising edge.
REQ-004 rst, input, 1: asynchronous, active-high reset.
REQ-005 line_in, input, 1: resolved wired-OR bus line; 0 is recessive (weak0), 1 is dominant (pull1).
REQ-006 bit_tick, input, 1: one-clk strobe marking the bit-sample point.
REQ-007 tx_active, input, 1: the local transmitter is driving the current frame.
REQ-008 tx_bit, input, 1: the bit the local transmitter drives for the current bit period.
REQ-009 rx_data, output, DATA_BITS: last good received payload, MSB first on the line.
REQ-010 rx_valid, output, 1: one-clk pulse when rx_data has been updated.
REQ-011 frame_err, output, 1: one-clk pulse on a bad stop bit.
REQ-012 arb_lost, output, 1: sticky flag; local 0 was overridden by a dominant 1.
REQ-013 busy, output, 1: high in every state except IDLE.

Function
REQ-014 line_in SHALL pass through SYNC_STAGES flops; all decisions use only the synchronized value (ls).
REQ-015 Frame format SHALL be: start bit 1, DATA_BITS data bits MSB first, [parity bit], stop bit 0. Idle line is 0.
REQ-016 The FSM SHALL have states IDLE, DATA, PAR, STOP. It SHALL advance only on clk cycles with bit_tick=1.
REQ-017 IDLE to DATA SHALL occur on a tick with ls=1. The bit counter SHALL clear to 0 and arb_lost SHALL clear.
REQ-018 In DATA, each tick SHALL shift ls into the shift register and increment the counter. After the tick with counter=DATA_BITS-1, the FSM SHALL go to PAR if the parity option is compiled in, otherwise to STOP.
REQ-019 In DATA, a tick with tx_active=1, tx_bit=0 and ls=1 SHALL set arb_lost. The flag SHALL hold until the next start or reset. Reception SHALL continue.
REQ-020 In STOP, a tick with ls=0 SHALL load rx_data from the shift register and pulse rx_valid on the following clk (1-clk latency).
REQ-021 In STOP, a tick with ls=1 SHALL pulse frame_err on the following clk and leave rx_data unchanged.
REQ-022 STOP SHALL always return to IDLE. A stop bit of 1 SHALL NOT be taken as a new start bit.
REQ-023 ls changes without a bit_tick SHALL have no effect on any state.
REQ-024 rx_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly 1 clk.

Reset
REQ-025 While rst=1, the FSM SHALL be IDLE. Synchronizer flops, counter and shift register SHALL be 0. rx_data=0, rx_valid=0, frame_err=0, arb_lost=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse. rst SHALL dominate all simultaneous events.

Configuration
REQ-027 Macro WOR_LINE_RX_PARITY_EN SHALL control an even-parity bit between the data bits and the stop bit.
REQ-028 When the macro is defined:
- Port parity_err (output, 1) SHALL exist.
- The PAR state SHALL sample one bit.
- A mismatch SHALL pulse parity_err with the same timing as rx_valid.
- On a mismatch, rx_valid SHALL be suppressed and rx_data SHALL NOT be updated.
- parity_err SHALL reset to 0.
REQ-029 When the macro is undefined, the PAR state and the parity_err port SHALL be absent, and frames SHALL carry no parity bit.

Verification
REQ-030 Drive 1,1,0,1,0,0,1,0,1,0 on ticks (start, 0xA5, stop) -> rx_valid pulses once, rx_data=0xA5, frame_err=0, arb_lost=0.
REQ-031 Drive 0x3C with stop bit 1 -> frame_err pulses once, no rx_valid, rx_data keeps its previous value, FSM returns to IDLE.
REQ-032 Drive tx_active=1 with tx_bit=0 while line_in=1 at data bit 3 of 0xFF -> arb_lost rises after that tick and stays 1 through rx_valid; the next start bit clears it.
REQ-033 Assert rst after data bit 4 -> all outputs 0, busy=0, no pulse; a following 0x5A frame receives correctly.
REQ-034 Pulse line_in=1 for 3 clks with no bit_tick -> busy stays 0, no outputs change.
REQ-035 With WOR_LINE_RX_PARITY_EN defined, send 0x01 with parity 0 -> parity_err pulses, no rx_valid; the same frame with parity 1 -> rx_valid, rx_data=0x01.
